jtframe_ba0_arb: RTL and testbench

Two-requester arbiter for one SDRAM bank port. It shares the bank between the game (requester A, high priority) and an auxiliary soft-CPU (requester B, low priority, strobe-driven). It sits between the game/CPU logic and the SDRAM controller's bank-0 interface. Starvation of B is bounded by a grant counter, and a watchdog releases a hung transaction.

---
 rtl/jtframe_ba0_arb.sv | 118 +++++++++++
 tb/tb_jtframe_ba0_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_ba0_arb.sv
// jtframe_ba0_arb: shares one SDRAM bank between a priority game port and a strobe-driven CPU port
module jtframe_ba0_arb #(
  parameter int AW     = 22,
  parameter int STARVE = 4,
  parameter int TOUT   = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  input  logic          a_rd,
  input  logic          a_wr,
  input  logic [15:0]   a_din,
  input  logic [1:0]    a_din_m,
  output logic          a_ack,
  output logic          a_dst,
  output logic          a_rdy,
  input  logic [AW-1:0] b_addr,
  input  logic          b_rd,
  input  logic          b_wr,
  input  logic [15:0]   b_din,
  input  logic [1:0]    b_din_m,
  output logic          b_busy,
  output logic [15:0]   b_dout,
  output logic [AW-1:0] ba_addr,
  output logic          ba_rd,
  output logic          ba_wr,
  output logic [15:0]   ba_din,
  output logic [1:0]    ba_din_m,
  input  logic          ba_ack,
  input  logic          ba_dst,
  input  logic          ba_rdy,
  input  logic [15:0]   ba_dout,
  output logic          owner,
  output logic          tout_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam int SW = $clog2(STARVE + 1) > 3 ? $clog2(STARVE + 1) : 3;
  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [7:0]      wd;
  logic            pend_b, b_wr_l, a_req, live;
  logic [AW-1:0]   b_addr_l;
  logic [15:0]     b_din_l;
  logic [1:0]      b_din_m_l;
  always_comb begin
    a_req    = a_rd | a_wr;
    live     = state != IDLE;
    ba_addr  = owner ? b_addr_l : a_addr;
    ba_din   = owner ? b_din_l : a_din;
    ba_din_m = owner ? b_din_m_l : a_din_m;
    ba_rd    = state == REQ && (owner ? !b_wr_l : a_rd);
    ba_wr    = state == REQ && (owner ? b_wr_l : a_wr);
    a_ack    = live & ~owner & ba_ack;
    a_dst    = live & ~owner & ba_dst;
    a_rdy    = live & ~owner & ba_rdy;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      pend_b     <= 1'b0;
      b_busy     <= 1'b0;
      b_wr_l     <= 1'b0;
      b_addr_l   <= '0;
      b_din_l    <= '0;
      b_din_m_l  <= '0;
      b_dout     <= '0;
      starve_cnt <= '0;
      wd         <= '0;
      tout_err   <= 1'b0;
    end else begin
      if (!pend_b) starve_cnt <= '0;
      if (!b_busy && (b_rd || b_wr)) begin
        pend_b    <= 1'b1;
        b_busy    <= 1'b1;
        b_wr_l    <= b_wr;
        b_addr_l  <= b_addr;
        b_din_l   <= b_din;
        b_din_m_l <= b_din_m;
      end
      if (live && owner && ba_dst) b_dout <= ba_dout;
      wd <= live ? wd + 8'd1 : 8'd0;
      case (state)
        IDLE:
          if (pend_b && (!a_req || starve_cnt == SW'(STARVE))) begin
            owner      <= 1'b1;
            state      <= REQ;
            starve_cnt <= '0;
          end else if (a_req) begin
            owner      <= 1'b0;
            state      <= REQ;
            starve_cnt <= starve_cnt + SW'(pend_b);
          end
        REQ:
          if (ba_ack) begin
            state <= ba_rdy ? IDLE : WAIT;
            if (owner) pend_b <= 1'b0;
            if (owner && ba_rdy) b_busy <= 1'b0;
          end else if (!owner && !a_req) state <= IDLE;
        WAIT:
          if (ba_rdy) begin
            state <= IDLE;
            if (owner) b_busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
      // watchdog overrides any handshake seen on the same edge
      if (live && wd == 8'(TOUT - 1)) begin
        state    <= IDLE;
        tout_err <= 1'b1;
        if (owner) begin
          pend_b <= 1'b0;
          b_busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtframe_ba0_arb.sv
// tb_jtframe_ba0_arb: directed checks of arbitration, starvation bound, watchdog and reset
module tb_jtframe_ba0_arb;
  localparam int AW = 22;
  logic clk = 0, rst_n = 0;
  logic [AW-1:0] a_addr, b_addr, ba_addr;
  logic a_rd, a_wr, a_ack, a_dst, a_rdy, b_rd, b_wr, b_busy;
  logic [15:0] a_din, b_din, b_dout, ba_din, ba_dout;
  logic [1:0] a_din_m, b_din_m, ba_din_m;
  logic ba_rd, ba_wr, ba_ack, ba_dst, ba_rdy, owner, tout_err;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  jtframe_ba0_arb #(.AW(AW), .STARVE(4), .TOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_addr(a_addr), .a_rd(a_rd), .a_wr(a_wr), .a_din(a_din), .a_din_m(a_din_m),
    .a_ack(a_ack), .a_dst(a_dst), .a_rdy(a_rdy),
    .b_addr(b_addr), .b_rd(b_rd), .b_wr(b_wr), .b_din(b_din), .b_din_m(b_din_m),
    .b_busy(b_busy), .b_dout(b_dout),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din), .ba_din_m(ba_din_m),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy), .ba_dout(ba_dout),
    .owner(owner), .tout_err(tout_err)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_addr = 22'h2AAAA; a_din = 16'h1234; a_din_m = 2'b10;
    a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0; b_addr = 0; b_din = 0; b_din_m = 0;
    ba_ack = 0; ba_dst = 0; ba_rdy = 0; ba_dout = 0;
    #2;
    n_chk++; if ({ba_rd, ba_wr} !== 2'b00) begin n_fail++; $display("FAIL reset_req: got %b want 00", {ba_rd, ba_wr}); end
    n_chk++; if ({owner, b_busy, tout_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {owner, b_busy, tout_err}); end
    n_chk++; if (b_dout !== 16'h0) begin n_fail++; $display("FAIL reset_b_dout: got %h want 0000", b_dout); end
    n_chk++; if ({ba_addr, ba_din, ba_din_m} !== {22'h2AAAA, 16'h1234, 2'b10}) begin n_fail++; $display("FAIL reset_mux: got %h/%h/%b want 2aaaa/1234/10", ba_addr, ba_din, ba_din_m); end
    @(negedge clk) rst_n = 1;
    cyc;
    ba_dst = 1; ba_ack = 1; ba_rdy = 1;
    #1;
    n_chk++; if ({a_ack, a_dst, a_rdy} !== 3'b000) begin n_fail++; $display("FAIL idle_no_forward: got %b want 000", {a_ack, a_dst, a_rdy}); end
    ba_dst = 0; ba_ack = 0; ba_rdy = 0;
  endtask

  task automatic test_a_read;
    cyc;
    a_rd = 1; a_addr = 22'h3ABCD;
    #1;
    n_chk++; if (ba_rd !== 1'b0) begin n_fail++; $display("FAIL a_read_c0: got %b want 0", ba_rd); end
    for (int c = 1; c <= 6; c++) begin
      cyc;
      a_rd = c <= 3; ba_ack = c == 3; ba_dst = c == 5; ba_rdy = c == 6;
      #1;
      n_chk++;
      if ({ba_rd, a_ack, a_dst, a_rdy, owner} !== {c >= 1 && c <= 3, c == 3, c == 5, c == 6, 1'b0}) begin
        n_fail++; $display("FAIL a_read_c%0d: got rd/ack/dst/rdy/own %b", c, {ba_rd, a_ack, a_dst, a_rdy, owner});
      end
    end
    cyc;
    ba_rdy = 0;
    #1;
    n_chk++; if (ba_rd !== 1'b0) begin n_fail++; $display("FAIL a_read_done: got %b want 0", ba_rd); end
  endtask

  task automatic test_b_write;
    b_wr = 1; b_addr = 22'h12345; b_din = 16'hBEEF; b_din_m = 2'b01;
    #1;
    n_chk++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL b_wr_pre: got busy %b want 0", b_busy); end
    cyc;
    b_wr = 0; b_addr = 22'h0; b_din = 16'h0; b_din_m = 2'b11;
    #1;
    n_chk++; if ({b_busy, ba_wr, owner} !== 3'b100) begin n_fail++; $display("FAIL b_wr_pend: got busy/wr/own %b want 100", {b_busy, ba_wr, owner}); end
    cyc;
    n_chk++; if ({ba_wr, ba_rd, owner, ba_addr, ba_din, ba_din_m} !== {3'b101, 22'h12345, 16'hBEEF, 2'b01}) begin
      n_fail++; $display("FAIL b_wr_req: got wr/rd/own %b addr %h din %h m %b", {ba_wr, ba_rd, owner}, ba_addr, ba_din, ba_din_m);
    end
    ba_ack = 1;
    #1;
    n_chk++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL b_wr_a_ack: got %b want 0", a_ack); end
    cyc;
    ba_ack = 0; ba_rdy = 1;
    #1;
    n_chk++; if ({ba_wr, b_busy, a_rdy} !== 3'b010) begin n_fail++; $display("FAIL b_wr_wait: got wr/busy/a_rdy %b want 010", {ba_wr, b_busy, a_rdy}); end
    cyc;
    ba_rdy = 0;
    #1;
    n_chk++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL b_wr_done: got busy %b want 0", b_busy); end
  endtask

  task automatic test_b_read_data;
    b_rd = 1; b_addr = 22'h00456;
    cyc;
    b_rd = 0;
    cyc;
    n_chk++; if ({ba_rd, owner, ba_addr} !== {2'b11, 22'h00456}) begin n_fail++; $display("FAIL b_rd_req: got rd/own %b addr %h", {ba_rd, owner}, ba_addr); end
    ba_ack = 1;
    cyc;
    ba_ack = 0; ba_dst = 1; ba_dout = 16'hA55A;
    #1;
    n_chk++; if (a_dst !== 1'b0) begin n_fail++; $display("FAIL b_rd_a_dst: got %b want 0", a_dst); end
    cyc;
    ba_dst = 0; ba_dout = 16'h0; ba_rdy = 1;
    cyc;
    ba_rdy = 0;
    #1;
    n_chk++; if ({b_dout, b_busy} !== {16'hA55A, 1'b0}) begin n_fail++; $display("FAIL b_rd_data: got %h busy %b want a55a 0", b_dout, b_busy); end
    a_rd = 1; a_addr = 22'h01000;
    cyc;
    ba_ack = 1;
    cyc;
    ba_ack = 0; a_rd = 0; ba_dst = 1; ba_dout = 16'h1111;
    #1;
    n_chk++; if (a_dst !== 1'b1) begin n_fail++; $display("FAIL a_dst_fwd: got %b want 1", a_dst); end
    cyc;
    ba_dst = 0; ba_rdy = 1;
    cyc;
    ba_rdy = 0;
    #1;
    n_chk++; if (b_dout !== 16'hA55A) begin n_fail++; $display("FAIL b_dout_hold: got %h want a55a", b_dout); end
  endtask

  task automatic test_starve;
    int acnt, round;
    bit strobed;
    acnt = 0; round = 0; strobed = 0;
    a_rd = 1; a_addr = 22'h00ABC;
    for (int i = 0; i < 200 && round < 2; i++) begin
      cyc;
      b_wr = 0; ba_ack = 0; ba_rdy = 0;
      #1;
      if (ba_rd | ba_wr) begin
        ba_ack = 1; ba_rdy = 1;
        if (owner) begin
          n_chk++; if (acnt !== 4) begin n_fail++; $display("FAIL starve_round%0d: got %0d A grants want 4", round, acnt); end
          round++; acnt = 0; strobed = 0;
        end else if (strobed) acnt++;
        else begin
          b_wr = 1; b_addr = 22'h00F00; b_din = 16'h5A5A; strobed = 1;
        end
      end
    end
    n_chk++; if (round !== 2) begin n_fail++; $display("FAIL starve_timeout: got %0d B grants want 2", round); end
    cyc;
    a_rd = 0; b_wr = 0; ba_ack = 0; ba_rdy = 0;
    cyc;
    cyc;
  endtask

  task automatic test_watchdog;
    int n;
    n = 0;
    b_rd = 1; b_addr = 22'h00777;
    cyc;
    b_rd = 0;
    for (int i = 0; i < 400; i++) begin
      cyc;
      if (ba_rd) n++;
      else if (n > 0) break;
    end
    n_chk++; if (n !== 255) begin n_fail++; $display("FAIL wd_len: got %0d cycles want 255", n); end
    n_chk++; if ({tout_err, b_busy} !== 2'b10) begin n_fail++; $display("FAIL wd_flags: got err/busy %b want 10", {tout_err, b_busy}); end
    n_chk++; if (b_dout !== 16'hA55A) begin n_fail++; $display("FAIL wd_b_dout: got %h want a55a", b_dout); end
    a_rd = 1; a_addr = 22'h02222;
    cyc;
    n_chk++; if ({ba_rd, owner, ba_addr} !== {2'b10, 22'h02222}) begin n_fail++; $display("FAIL wd_next_a: got rd/own %b addr %h", {ba_rd, owner}, ba_addr); end
    ba_ack = 1; ba_rdy = 1;
    #1;
    n_chk++; if ({a_ack, a_rdy} !== 2'b11) begin n_fail++; $display("FAIL wd_next_ack: got %b want 11", {a_ack, a_rdy}); end
    cyc;
    a_rd = 0; ba_ack = 0; ba_rdy = 0;
    #1;
    n_chk++; if ({ba_rd, tout_err} !== 2'b01) begin n_fail++; $display("FAIL wd_sticky: got rd/err %b want 01", {ba_rd, tout_err}); end
  endtask

  task automatic test_reset_mid;
    b_rd = 1; b_addr = 22'h0ABCD;
    cyc;
    b_rd = 0;
    cyc;
    ba_ack = 1;
    cyc;
    ba_ack = 0;
    #1;
    n_chk++; if ({owner, b_busy, ba_rd} !== 3'b110) begin n_fail++; $display("FAIL mid_wait: got own/busy/rd %b want 110", {owner, b_busy, ba_rd}); end
    rst_n = 0;
    #1;
    n_chk++; if ({owner, b_busy, tout_err, ba_rd, ba_wr} !== 5'b0) begin n_fail++; $display("FAIL mid_reset_flags: got %b want 00000", {owner, b_busy, tout_err, ba_rd, ba_wr}); end
    n_chk++; if ({b_dout, ba_addr} !== {16'h0, a_addr}) begin n_fail++; $display("FAIL mid_reset_data: got %h/%h want 0000/%h", b_dout, ba_addr, a_addr); end
    @(negedge clk) rst_n = 1;
    cyc;
    n_chk++; if ({ba_rd, ba_wr, b_busy} !== 3'b000) begin n_fail++; $display("FAIL mid_release: got %b want 000", {ba_rd, ba_wr, b_busy}); end
  endtask

  initial begin
    test_reset;
    test_a_read;
    test_b_write;
    test_b_read_data;
    test_starve;
    test_watchdog;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
